// File: rtl/dvr_rr_arbiter.sv
// Round-robin N:1 data/valid/ready merge into one registered output stage.
// With PKT_MODE=1 the grant stays with one channel from its first beat until its s_last beat.
module dvr_rr_arbiter #(
    parameter int DATA_WIDTH = 128,
    parameter int NUM_CH     = 4,
    parameter int PKT_MODE   = 0,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH*DATA_WIDTH-1:0] s_data,
    input  logic [NUM_CH-1:0]            s_valid,
    input  logic [NUM_CH-1:0]            s_last,
    output logic [NUM_CH-1:0]            s_ready,
    output logic [DATA_WIDTH-1:0]        m_data,
    output logic                         m_valid,
    output logic                         m_last,
    output logic [CH_W-1:0]              m_chan,
    input  logic                         m_ready
);

    // state     | meaning
    // ST_IDLE   | round-robin grant from ptr_q on every beat
    // ST_LOCKED | packet in flight, only lock_ch_q may be granted
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [CH_W-1:0]       ptr_q, ptr_d;
    logic [CH_W-1:0]       lock_ch_q, lock_ch_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic                  m_valid_q, m_valid_d;
    logic                  m_last_q, m_last_d;
    logic [CH_W-1:0]       m_chan_q, m_chan_d;

    logic                  load;
    logic                  accept;
    logic                  scan_found;
    logic [CH_W-1:0]       scan_ch;
    logic [CH_W-1:0]       gnt_ch;
    logic [CH_W-1:0]       gnt_next;
    logic [CH_W:0]         cand;
    logic [NUM_CH-1:0]     gnt_vec;

    assign load = !m_valid_q || m_ready;

    // One spare bit on cand lets the wrap work for any NUM_CH, not just powers of two.
    always_comb begin
        scan_found = 1'b0;
        scan_ch    = '0;
        cand       = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = {1'b0, ptr_q} + (CH_W+1)'(i);
            if (cand >= (CH_W+1)'(NUM_CH)) begin
                cand = cand - (CH_W+1)'(NUM_CH);
            end
            if (!scan_found && s_valid[cand[CH_W-1:0]]) begin
                scan_found = 1'b1;
                scan_ch    = cand[CH_W-1:0];
            end
        end
    end

    always_comb begin
        gnt_ch  = scan_ch;
        gnt_vec = '0;
        if (PKT_MODE != 0 && state_q == ST_LOCKED) begin
            gnt_ch             = lock_ch_q;
            gnt_vec[lock_ch_q] = s_valid[lock_ch_q];
        end else if (scan_found) begin
            gnt_vec[scan_ch] = 1'b1;
        end
    end

    assign s_ready  = (load && !rst) ? gnt_vec : '0;
    assign accept   = |(s_ready & s_valid);
    assign gnt_next = (gnt_ch == CH_W'(NUM_CH - 1)) ? '0 : gnt_ch + CH_W'(1);

    always_comb begin
        state_d   = state_q;
        lock_ch_d = lock_ch_q;
        ptr_d     = ptr_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        m_chan_d  = m_chan_q;
        if (load) begin
            m_valid_d = accept;
        end
        if (accept) begin
            ptr_d    = gnt_next;
            m_data_d = s_data[gnt_ch*DATA_WIDTH +: DATA_WIDTH];
            m_chan_d = gnt_ch;
            m_last_d = (PKT_MODE != 0) ? s_last[gnt_ch] : 1'b1;
            if (PKT_MODE != 0) begin
                lock_ch_d = gnt_ch;
                state_d   = s_last[gnt_ch] ? ST_IDLE : ST_LOCKED;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            lock_ch_q <= '0;
            ptr_q     <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
            m_chan_q  <= '0;
        end else begin
            state_q   <= state_d;
            lock_ch_q <= lock_ch_d;
            ptr_q     <= ptr_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
            m_chan_q  <= m_chan_d;
        end
    end

    assign m_data  = m_data_q;
    assign m_valid = m_valid_q;
    assign m_last  = m_last_q;
    assign m_chan  = m_chan_q;

endmodule

// File: tb/tb_dvr_rr_arbiter.sv
// Scoreboard bench for dvr_rr_arbiter: three instances (4ch beat mode, 3ch beat mode, 4ch packet mode).
module tb_dvr_rr_arbiter;

    localparam int DW = 16;

    typedef struct packed {
        logic [3:0]    ch;
        logic [DW-1:0] d;
        logic          l;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   a_beats     = 0;

    logic [4*DW-1:0] a_data;
    logic [3:0]      a_valid, a_last, a_ready;
    logic [DW-1:0]   a_mdata;
    logic            a_mvalid, a_mlast, a_mready;
    logic [1:0]      a_mchan;

    logic [3*DW-1:0] b_data;
    logic [2:0]      b_valid, b_last, b_ready;
    logic [DW-1:0]   b_mdata;
    logic            b_mvalid, b_mlast, b_mready;
    logic [1:0]      b_mchan;

    logic [4*DW-1:0] c_data;
    logic [3:0]      c_valid, c_last, c_ready;
    logic [DW-1:0]   c_mdata;
    logic            c_mvalid, c_mlast, c_mready;
    logic [1:0]      c_mchan;

    dvr_rr_arbiter #(.DATA_WIDTH(DW), .NUM_CH(4), .PKT_MODE(0)) u_a (
        .clk(clk), .rst(rst), .s_data(a_data), .s_valid(a_valid), .s_last(a_last),
        .s_ready(a_ready), .m_data(a_mdata), .m_valid(a_mvalid), .m_last(a_mlast),
        .m_chan(a_mchan), .m_ready(a_mready)
    );

    dvr_rr_arbiter #(.DATA_WIDTH(DW), .NUM_CH(3), .PKT_MODE(0)) u_b (
        .clk(clk), .rst(rst), .s_data(b_data), .s_valid(b_valid), .s_last(b_last),
        .s_ready(b_ready), .m_data(b_mdata), .m_valid(b_mvalid), .m_last(b_mlast),
        .m_chan(b_mchan), .m_ready(b_mready)
    );

    dvr_rr_arbiter #(.DATA_WIDTH(DW), .NUM_CH(4), .PKT_MODE(1)) u_c (
        .clk(clk), .rst(rst), .s_data(c_data), .s_valid(c_valid), .s_last(c_last),
        .s_ready(c_ready), .m_data(c_mdata), .m_valid(c_mvalid), .m_last(c_mlast),
        .m_chan(c_mchan), .m_ready(c_mready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input int ch, input logic [DW-1:0] d, input logic l);
        exp_t e;
        e.ch = 4'(ch);
        e.d  = d;
        e.l  = l;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && a_mvalid && a_mready) begin
            a_beats++;
            if (qa.size() == 0) chk("a_unexpected_beat", 32'(a_mchan), 32'hF);
            else begin
                e = qa.pop_front();
                chk("a_chan", 32'(a_mchan), 32'(e.ch));
                chk("a_data", 32'(a_mdata), 32'(e.d));
                chk("a_last", 32'(a_mlast), 32'(e.l));
            end
        end
        if (!rst && b_mvalid && b_mready) begin
            if (qb.size() == 0) chk("b_unexpected_beat", 32'(b_mchan), 32'hF);
            else begin
                e = qb.pop_front();
                chk("b_chan", 32'(b_mchan), 32'(e.ch));
                chk("b_data", 32'(b_mdata), 32'(e.d));
                chk("b_last", 32'(b_mlast), 32'(e.l));
            end
        end
        if (!rst && c_mvalid && c_mready) begin
            if (qc.size() == 0) chk("c_unexpected_beat", 32'(c_mchan), 32'hF);
            else begin
                e = qc.pop_front();
                chk("c_chan", 32'(c_mchan), 32'(e.ch));
                chk("c_data", 32'(c_mdata), 32'(e.d));
                chk("c_last", 32'(c_mlast), 32'(e.l));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        a_data   = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
        b_data   = {16'hB002, 16'hB001, 16'hB000};
        c_data   = {16'hC003, 16'hC002, 16'hC001, 16'hC000};
        a_valid  = 4'hF;  a_last = 4'h0;  a_mready = 1'b1;
        b_valid  = 3'h7;  b_last = 3'h0;  b_mready = 1'b1;
        c_valid  = 4'hF;  c_last = 4'h0;  c_mready = 1'b1;

        // reset held 3 cycles with every channel valid
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_a_ready",  32'(a_ready),  32'h0);
            chk("rst_a_mvalid", 32'(a_mvalid), 32'h0);
            chk("rst_a_mdata",  32'(a_mdata),  32'h0);
            chk("rst_a_mchan",  32'(a_mchan),  32'h0);
            chk("rst_b_ready",  32'(b_ready),  32'h0);
            chk("rst_c_ready",  32'(c_ready),  32'h0);
            chk("rst_c_mlast",  32'(c_mlast),  32'h0);
        end
        rst     = 1'b0;
        b_valid = 3'h0;
        c_valid = 4'h0;
        for (int k = 0; k < 8; k++) qa.push_back(mk(k % 4, 16'hA000 + 16'(k % 4), 1'b1));
        #1;
        chk("first_grant_ch0", 32'(a_ready), 32'h1);

        // fairness: all valid, 8 beats in 8 cycles
        repeat (8) tick();
        a_valid = 4'h0;
        tick();
        chk("fair_beat_count", 32'(a_beats), 32'd8);
        chk("fair_idle_mvalid", 32'(a_mvalid), 32'h0);
        chk("fair_drained", 32'(qa.size()), 32'd0);

        // wrap and skip with ch1/ch3 only
        a_valid = 4'b1010;
        qa.push_back(mk(1, 16'hA001, 1'b1));
        qa.push_back(mk(3, 16'hA003, 1'b1));
        qa.push_back(mk(1, 16'hA001, 1'b1));
        qa.push_back(mk(3, 16'hA003, 1'b1));
        qa.push_back(mk(1, 16'hA001, 1'b1));
        repeat (5) tick();
        a_valid = 4'h0;
        tick();
        chk("wrap_drained", 32'(qa.size()), 32'd0);

        // backpressure on a held 0xA5 from ch2
        a_data[2*DW +: DW] = 16'h00A5;
        a_valid = 4'b0100;
        qa.push_back(mk(2, 16'h00A5, 1'b1));
        qa.push_back(mk(0, 16'hA000, 1'b1));
        tick();
        a_mready = 1'b0;
        a_data[2*DW +: DW] = 16'h00B6;
        a_valid = 4'b0101;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_ready",  32'(a_ready),  32'h0);
            chk("bp_mvalid", 32'(a_mvalid), 32'h1);
            chk("bp_mdata",  32'(a_mdata),  32'h00A5);
            chk("bp_mchan",  32'(a_mchan),  32'h2);
            @(posedge clk);
        end
        #1;
        a_mready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 32'(a_ready), 32'h1);
        tick();
        a_valid = 4'h0;
        tick();
        chk("bp_drained", 32'(qa.size()), 32'd0);

        // 3-channel wrap: ch2 then ch0
        b_valid = 3'b100;
        qb.push_back(mk(2, 16'hB002, 1'b1));
        qb.push_back(mk(0, 16'hB000, 1'b1));
        qb.push_back(mk(2, 16'hB002, 1'b1));
        qb.push_back(mk(0, 16'hB000, 1'b1));
        qb.push_back(mk(2, 16'hB002, 1'b1));
        tick();
        b_valid = 3'b101;
        repeat (4) tick();
        b_valid = 3'h0;
        tick();
        chk("b_wrap_drained", 32'(qb.size()), 32'd0);

        // packet lock: ch0 3-beat packet with a gap, ch1 always valid
        c_data[0 +: DW] = 16'hC0B1;
        c_last  = 4'b0010;
        c_valid = 4'b0011;
        qc.push_back(mk(0, 16'hC0B1, 1'b0));
        qc.push_back(mk(0, 16'hC0B2, 1'b0));
        qc.push_back(mk(0, 16'hC0B3, 1'b1));
        qc.push_back(mk(1, 16'hC001, 1'b1));
        @(negedge clk); chk("pkt_beat1_ready", 32'(c_ready), 32'h1);
        tick();
        c_valid = 4'b0010;
        @(negedge clk); chk("pkt_gap_ready", 32'(c_ready), 32'h0);
        tick();
        c_valid = 4'b0011;
        c_data[0 +: DW] = 16'hC0B2;
        @(negedge clk); chk("pkt_beat2_ready", 32'(c_ready), 32'h1);
        tick();
        c_data[0 +: DW] = 16'hC0B3;
        c_last[0] = 1'b1;
        @(negedge clk); chk("pkt_beat3_ready", 32'(c_ready), 32'h1);
        tick();
        c_valid = 4'b0010;
        @(negedge clk); chk("pkt_ch1_ready", 32'(c_ready), 32'h2);
        tick();
        c_valid = 4'h0;
        tick();
        chk("pkt_drained", 32'(qc.size()), 32'd0);

        // reset in the middle of a ch2 packet
        c_last  = 4'b0000;
        c_data[2*DW +: DW] = 16'hC2B1;
        c_valid = 4'b0100;
        qc.push_back(mk(2, 16'hC2B1, 1'b0));
        @(negedge clk); chk("mid_beat1_ready", 32'(c_ready), 32'h4);
        tick();
        c_data[2*DW +: DW] = 16'hC2B2;
        c_data[0 +: DW]    = 16'hC0C0;
        c_last  = 4'b0001;
        c_valid = 4'b0101;
        @(negedge clk); chk("mid_locked_ready", 32'(c_ready), 32'h4);
        tick();
        rst      = 1'b1;
        c_mready = 1'b0;
        @(negedge clk);
        chk("mid_rst_ready", 32'(c_ready), 32'h0);
        chk("mid_held_mvalid", 32'(c_mvalid), 32'h1);
        tick();
        chk("mid_after_rst_mvalid", 32'(c_mvalid), 32'h0);
        chk("mid_after_rst_mchan", 32'(c_mchan), 32'h0);
        rst      = 1'b0;
        c_mready = 1'b1;
        qc.push_back(mk(0, 16'hC0C0, 1'b1));
        @(negedge clk); chk("mid_regrant_ready", 32'(c_ready), 32'h1);
        tick();
        c_valid = 4'h0;
        tick();
        chk("mid_drained", 32'(qc.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dvr_rr_arbiter.md
# dvr_rr_arbiter

Parametrised N-to-1 data/valid/ready arbiter that merges `NUM_CH` independent streams into one output stream using round-robin fairness. Optional packet mode holds a grant until the beat with `s_last` is accepted. The output is fully registered and sustains one beat per cycle. It sits between several DVR producers and a single shared DVR consumer.

## Interface
- `DATA_WIDTH`, 128, payload width per channel.
- `NUM_CH`, 4, number of input channels (2..16).
- `PKT_MODE`, 0. 0 = arbitrate every beat. 1 = hold grant until the `s_last` beat is accepted.
- `CH_W`, `$clog2(NUM_CH)`, derived local parameter; width of `m_chan`.

- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `s_data`  in  `NUM_CH*DATA_WIDTH`  channel i occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `s_valid`  in  `NUM_CH`  per-channel valid.
- `s_last`  in  `NUM_CH`  per-channel end of packet. Ignored when `PKT_MODE=0`.
- `s_ready`  out  `NUM_CH`  per-channel ready. Combinational; at most one bit is high.
- `m_data`  out  `DATA_WIDTH`  registered output payload.
- `m_valid`  out  1  registered output valid.
- `m_last`  out  1  registered copy of the accepted `s_last`. Forced to 1 when `PKT_MODE=0`.
- `m_chan`  out  `CH_W`  source channel of the current `m_data`.
- `m_ready`  in  1  downstream ready.

## Operation
- The output register is a single pipeline stage.
  - `load = !m_valid || m_ready`.
  - A beat moves from channel i to the output when `load && s_valid[i] && grant==i`.
- Handshake rules:
  - A transfer occurs on any edge where valid and ready are both high.
  - Once `m_valid` is high, `m_data`, `m_chan` and `m_last` hold stable until `m_ready` is sampled high.
- `s_ready[i] = load && gnt_vec[i]`.
  - `gnt_vec` is one-hot or zero.
  - `s_ready` may depend on `s_valid`.
  - `s_ready` is 0 while `rst` is high.
- Round-robin selection:
  - Priority pointer `ptr` (`CH_W` bits) names the highest-priority channel.
  - The grant goes to the first channel with `s_valid` set, scanning `ptr, ptr+1, …, NUM_CH-1, 0, …`, modulo `NUM_CH`. Wrap works for non-power-of-2 `NUM_CH`.
  - After an accepted beat from channel g, `ptr <= (g==NUM_CH-1) ? 0 : g+1`.
  - If no beat is accepted, `ptr` is unchanged.
- Packet mode (`PKT_MODE=1`):
  - States: IDLE and LOCKED(ch).
  - IDLE: round-robin as above. An accepted beat with `s_last=0` moves to LOCKED(g) and stores `lock_ch=g`.
  - LOCKED: only `lock_ch` may be granted; other channels stay `s_ready=0` even if `lock_ch` drops valid.
  - LOCKED: an accepted beat with `s_last=1` returns to IDLE and sets `ptr <= lock_ch+1` (wrapped).
  - An accepted single-beat packet (`s_last=1` from IDLE) stays in IDLE.
- Reset (synchronous, takes priority over every other update):
  - `m_valid=0`, `m_data=0`, `m_last=0`, `m_chan=0`.
  - `ptr=0`, state IDLE.
  - Reset mid-packet drops the lock; the beat held in the output register is discarded.
- When all `s_valid` are 0, no grant is made and `m_valid` clears on `m_ready`.
- When `NUM_CH=1`, the block degenerates to a registered pipe: `m_chan=0`.

## Timing
- Latency: a beat accepted at edge k appears on `m_*` after edge k and can be consumed at edge k+1.
- Throughput: 1 beat/cycle with `m_ready` held at 1. No bubble on grant switch or at packet boundaries.
- Backpressure: while `m_valid && !m_ready`, all `s_ready` are 0. The next edge with `m_ready=1` both drains and reloads.
- Critical path: `m_ready` → `load` → `s_ready`, plus the priority scan over `NUM_CH`. No combinational path from `s_*` to `m_*`.
- First cycle after `rst` deasserts: channel 0 has top priority.

## Test plan
- **Reset values:** `rst=1` for 3 cycles with all `s_valid=1` → `s_ready=0`, `m_valid=0`, `m_data=0`, `m_chan=0` throughout. First grant after release goes to ch0.
- **Fairness:** `NUM_CH=4`, `PKT_MODE=0`, all channels always valid, `m_ready=1` for 8 cycles → `m_chan` sequence 0,1,2,3,0,1,2,3, one beat per cycle.
- **Wrap and skip:** only ch1 and ch3 valid, `m_ready=1` → `m_chan` alternates 3,1,3,1 after the first beat 1. Repeat with `NUM_CH=3`: ch2 then ch0 wraps correctly.
- **Backpressure:** `m_ready=0` for 5 cycles while ch2 holds `m_data=0xA5` → output stable, all `s_ready=0`. Releasing `m_ready` drains 0xA5 and loads the next beat on the same edge.
- **Packet lock:** `PKT_MODE=1`, ch0 sends a 3-beat packet (last on beat 3) with a 1-cycle valid gap; ch1 always valid → ch1 never granted until ch0's last beat is accepted. Then ch1 is granted and `m_last` marks beat 3.
- **Reset mid-packet:** `PKT_MODE=1`, assert `rst` after beat 2 of a ch2 packet → lock cleared, `m_valid=0`, next grant is ch0 if valid.
